// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencer: FSM state encoding and
// default sizing of the counter value and the lap buffer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        REVIEW = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_IDXW  = 2;

endpackage

// File: rtl/lap_mem.sv
// Lap snapshot register file: synchronous write, asynchronous read, no reset.
module lap_mem
    import stopwatch_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned IDXW  = DEF_IDXW
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDXW-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDXW-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/lap_ctl.sv
// Stopwatch sequencer: start/stop/clear control of the counter, lap capture
// into lap_mem, and selection of live count or stored lap for the display.
module lap_ctl
    import stopwatch_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned IDXW  = DEF_IDXW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig,
    input  logic             split,
    input  logic             review,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             init_regs,
    output logic             count_enabled,
    output logic [WIDTH-1:0] disp_value,
    output logic [IDXW:0]    lap_count,
    output logic [IDXW-1:0]  lap_idx,
    output logic             lap_full,
    output logic             lap_ovf
);

    localparam logic [IDXW:0]   LAP_MAX = (IDXW+1)'(DEPTH);
    localparam logic [IDXW:0]   CNT_ONE = (IDXW+1)'(1);
    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

    state_t           r_state;
    logic             r_init_regs;
    logic             r_count_enabled;
    logic [WIDTH-1:0] r_disp_value;
    logic [IDXW:0]    r_lap_count;
    logic [IDXW-1:0]  r_lap_idx;
    logic             r_lap_ovf;

    logic             w_trig;
    logic             w_split;
    logic             w_review;
    logic             w_full;
    logic             w_last;
    logic             w_we;
    logic             w_to_review;
    logic [IDXW-1:0]  w_raddr;
    logic [WIDTH-1:0] w_rdata;

    // Only the highest-priority pulse of a coincident set acts.
    assign w_trig   = trig;
    assign w_split  = split & ~trig;
    assign w_review = review & ~trig & ~split;

    assign w_full = (r_lap_count == LAP_MAX);
    assign w_last = ({1'b0, r_lap_idx} == (r_lap_count - CNT_ONE));
    assign w_we   = (r_state == RUN) && w_split && !w_full;

    // Read address is the index REVIEW will hold after this edge, so the lap
    // lands on the display on the same edge that enters or advances REVIEW.
    always_comb begin
        w_raddr     = r_lap_idx;
        w_to_review = 1'b0;
        case (r_state)
            PAUSED: begin
                if (w_review && (r_lap_count != '0)) begin
                    w_raddr     = '0;
                    w_to_review = 1'b1;
                end
            end
            REVIEW: begin
                if (!w_trig && !w_split) begin
                    w_to_review = 1'b1;
                    if (w_review) begin
                        w_raddr = w_last ? '0 : (r_lap_idx + IDX_ONE);
                    end
                end
            end
            default: ;
        endcase
    end

    lap_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .IDXW (IDXW)
    ) u_lap_mem (
        .clk  (clk),
        .we   (w_we),
        .waddr(r_lap_count[IDXW-1:0]),
        .wdata(cnt_value),
        .raddr(w_raddr),
        .rdata(w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_init_regs     <= 1'b1;
            r_count_enabled <= 1'b0;
            r_disp_value    <= '0;
            r_lap_count     <= '0;
            r_lap_idx       <= '0;
            r_lap_ovf       <= 1'b0;
        end else begin
            r_disp_value <= w_to_review ? w_rdata : cnt_value;
            case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        r_state         <= RUN;
                        r_init_regs     <= 1'b0;
                        r_count_enabled <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_trig) begin
                        r_state         <= PAUSED;
                        r_count_enabled <= 1'b0;
                    end else if (w_split) begin
                        if (w_full) begin
                            r_lap_ovf <= 1'b1;
                        end else begin
                            r_lap_count <= r_lap_count + CNT_ONE;
                        end
                    end
                end
                PAUSED: begin
                    if (w_trig) begin
                        r_state         <= RUN;
                        r_count_enabled <= 1'b1;
                    end else if (w_split) begin
                        r_state     <= IDLE;
                        r_init_regs <= 1'b1;
                        r_lap_count <= '0;
                        r_lap_idx   <= '0;
                        r_lap_ovf   <= 1'b0;
                    end else if (w_review && (r_lap_count != '0)) begin
                        r_state   <= REVIEW;
                        r_lap_idx <= '0;
                    end
                end
                REVIEW: begin
                    if (w_trig) begin
                        r_state   <= PAUSED;
                        r_lap_idx <= '0;
                    end else if (w_split) begin
                        r_state     <= IDLE;
                        r_init_regs <= 1'b1;
                        r_lap_count <= '0;
                        r_lap_idx   <= '0;
                        r_lap_ovf   <= 1'b0;
                    end else if (w_review) begin
                        r_lap_idx <= w_raddr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign init_regs     = r_init_regs;
    assign count_enabled = r_count_enabled;
    assign disp_value    = r_disp_value;
    assign lap_count     = r_lap_count;
    assign lap_idx       = r_lap_idx;
    assign lap_full      = w_full;
    assign lap_ovf       = r_lap_ovf;

endmodule

// File: tb/tb_lap_ctl.sv
// Self-checking bench for lap_ctl: a behavioural model pushes expected outputs
// per driven cycle; they are popped and compared one cycle later.
module tb_lap_ctl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int IDXW  = 2;

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;
    localparam int S_REVIEW = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             trig = 1'b0;
    logic             split = 1'b0;
    logic             review = 1'b0;
    logic [WIDTH-1:0] cnt_value = '0;
    logic             init_regs;
    logic             count_enabled;
    logic [WIDTH-1:0] disp_value;
    logic [IDXW:0]    lap_count;
    logic [IDXW-1:0]  lap_idx;
    logic             lap_full;
    logic             lap_ovf;

    lap_ctl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .IDXW (IDXW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .trig         (trig),
        .split        (split),
        .review       (review),
        .cnt_value    (cnt_value),
        .init_regs    (init_regs),
        .count_enabled(count_enabled),
        .disp_value   (disp_value),
        .lap_count    (lap_count),
        .lap_idx      (lap_idx),
        .lap_full     (lap_full),
        .lap_ovf      (lap_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             init_regs;
        logic             count_enabled;
        logic [WIDTH-1:0] disp;
        int               cnt;
        int               idx;
        logic             full;
        logic             ovf;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    int               m_st  = S_IDLE;
    int               m_cnt = 0;
    int               m_idx = 0;
    logic             m_ovf = 1'b0;
    logic [WIDTH-1:0] m_disp = '0;
    logic [WIDTH-1:0] m_mem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic rst, input logic t, input logic s, input logic r,
                         input logic [WIDTH-1:0] v);
        if (rst) begin
            m_st   = S_IDLE;
            m_cnt  = 0;
            m_idx  = 0;
            m_ovf  = 1'b0;
            m_disp = '0;
        end else begin
            case (m_st)
                S_IDLE: if (t) m_st = S_RUN;
                S_RUN: begin
                    if (t) m_st = S_PAUSED;
                    else if (s) begin
                        if (m_cnt == DEPTH) m_ovf = 1'b1;
                        else begin
                            m_mem[m_cnt] = v;
                            m_cnt++;
                        end
                    end
                end
                S_PAUSED: begin
                    if (t) m_st = S_RUN;
                    else if (s) begin
                        m_st = S_IDLE; m_cnt = 0; m_idx = 0; m_ovf = 1'b0;
                    end else if (r && m_cnt > 0) begin
                        m_st = S_REVIEW; m_idx = 0;
                    end
                end
                default: begin
                    if (t) begin
                        m_st = S_PAUSED; m_idx = 0;
                    end else if (s) begin
                        m_st = S_IDLE; m_cnt = 0; m_idx = 0; m_ovf = 1'b0;
                    end else if (r) begin
                        m_idx = (m_idx == m_cnt - 1) ? 0 : m_idx + 1;
                    end
                end
            endcase
            m_disp = (m_st == S_REVIEW) ? m_mem[m_idx] : v;
        end
    endtask

    task automatic step(input logic rst, input logic t, input logic s, input logic r,
                        input logic [WIDTH-1:0] v);
        exp_t e;
        reset = rst; trig = t; split = s; review = r; cnt_value = v;
        model(rst, t, s, r, v);
        e.init_regs     = (m_st == S_IDLE);
        e.count_enabled = (m_st == S_RUN);
        e.disp          = m_disp;
        e.cnt           = m_cnt;
        e.idx           = m_idx;
        e.full          = (m_cnt == DEPTH);
        e.ovf           = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("init_regs",     32'(init_regs),     32'(e.init_regs));
        chk("count_enabled", 32'(count_enabled), 32'(e.count_enabled));
        chk("disp_value",    32'(disp_value),    32'(e.disp));
        chk("lap_count",     32'(lap_count),     32'(e.cnt));
        chk("lap_idx",       32'(lap_idx),       32'(e.idx));
        chk("lap_full",      32'(lap_full),      32'(e.full));
        chk("lap_ovf",       32'(lap_ovf),       32'(e.ovf));
        reset = 1'b0; trig = 1'b0; split = 1'b0; review = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, WIDTH'($urandom));
    endtask

    initial begin
        // 1: reset and start
        step(1, 0, 0, 0, 16'h1111);
        step(1, 0, 0, 0, 16'h2222);
        chk("t1_init", 32'(init_regs), 32'd1);
        chk("t1_ce", 32'(count_enabled), 32'd0);
        chk("t1_disp", 32'(disp_value), 32'd0);
        chk("t1_cnt", 32'(lap_count), 32'd0);
        step(0, 1, 0, 0, 16'h0005);
        chk("t1_run_ce", 32'(count_enabled), 32'd1);
        chk("t1_run_init", 32'(init_regs), 32'd0);

        // 2: two laps, review with wrap
        step(0, 0, 1, 0, 16'h0123);
        idle(2);
        step(0, 0, 1, 0, 16'h0456);
        chk("t2_cnt", 32'(lap_count), 32'd2);
        step(0, 1, 0, 0, 16'h0500);
        step(0, 0, 0, 1, 16'h0500);
        chk("t2_rev0", 32'(disp_value), 32'h0123);
        chk("t2_idx0", 32'(lap_idx), 32'd0);
        step(0, 0, 0, 1, 16'h0500);
        chk("t2_rev1", 32'(disp_value), 32'h0456);
        chk("t2_idx1", 32'(lap_idx), 32'd1);
        step(0, 0, 0, 1, 16'h0500);
        chk("t2_wrap", 32'(disp_value), 32'h0123);
        chk("t2_wrap_idx", 32'(lap_idx), 32'd0);
        step(0, 1, 0, 0, 16'h0501);
        step(0, 0, 1, 0, 16'h0502);
        step(0, 1, 0, 0, 16'h0000);

        // 3: overflow at DEPTH
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 16'h1000 + 16'(i));
        chk("t3_cnt", 32'(lap_count), 32'd4);
        chk("t3_full", 32'(lap_full), 32'd1);
        chk("t3_ovf", 32'(lap_ovf), 32'd1);
        step(0, 1, 0, 0, 16'h2000);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 16'h2000);
        chk("t3_mem3", 32'(disp_value), 32'h1003);
        step(0, 1, 0, 0, 16'h2001);
        step(0, 0, 1, 0, 16'h2002);
        chk("t3_clr_cnt", 32'(lap_count), 32'd0);
        chk("t3_clr_ovf", 32'(lap_ovf), 32'd0);
        chk("t3_clr_init", 32'(init_regs), 32'd1);

        // 4: coincident pulses
        step(0, 1, 0, 0, 16'h0000);
        step(0, 0, 1, 0, 16'h0777);
        step(0, 1, 1, 0, 16'h0778);
        chk("t4_cnt", 32'(lap_count), 32'd1);
        chk("t4_paused_ce", 32'(count_enabled), 32'd0);
        step(0, 0, 1, 1, 16'h0779);
        chk("t4_idle", 32'(init_regs), 32'd1);
        chk("t4_idle_cnt", 32'(lap_count), 32'd0);

        // 5: review with nothing stored, and in IDLE/RUN
        step(0, 1, 0, 0, 16'h0000);
        step(0, 1, 0, 0, 16'h0010);
        step(0, 0, 0, 1, 16'h0abc);
        chk("t5_disp", 32'(disp_value), 32'h0abc);
        chk("t5_idx", 32'(lap_idx), 32'd0);
        step(0, 1, 0, 0, 16'h0abd);
        step(0, 0, 0, 1, 16'h0abe);
        chk("t5_run_rev", 32'(count_enabled), 32'd1);
        step(0, 1, 0, 0, 16'h0abf);
        step(0, 0, 1, 0, 16'h0000);
        step(0, 0, 0, 1, 16'h0001);
        chk("t5_idle_rev", 32'(init_regs), 32'd1);

        // 6: reset in REVIEW together with trig
        step(0, 1, 0, 0, 16'h0000);
        step(0, 0, 1, 0, 16'h0321);
        step(0, 1, 0, 0, 16'h0322);
        step(0, 0, 0, 1, 16'h0323);
        chk("t6_in_review", 32'(disp_value), 32'h0321);
        step(1, 1, 0, 0, 16'h0324);
        chk("t6_rst_init", 32'(init_regs), 32'd1);
        chk("t6_rst_disp", 32'(disp_value), 32'd0);
        chk("t6_rst_cnt", 32'(lap_count), 32'd0);
        step(0, 1, 0, 0, 16'h0000);
        chk("t6_fresh_ce", 32'(count_enabled), 32'd1);
        chk("t6_fresh_cnt", 32'(lap_count), 32'd0);

        // randomised pulse traffic against the model
        for (int i = 0; i < 200; i++) begin
            step(logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 5) == 0),
                 logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 2) == 0),
                 WIDTH'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lap_ctl.md
Name: lap_ctl

Overview:
- Top-level stopwatch sequencer with lap memory; replaces the bare two-button control.
- Gates the time counter through init_regs and count_enabled, and captures split/lap snapshots of the counter value into a small buffer.
- Selects what the display shows: the live count, or a stored lap in review mode.
- Sits between the debounced button pulses and the counter/display datapath.

Parameters:
- WIDTH, 16, bit width of the counter value (e.g. 4 BCD digits).
- DEPTH, 4, number of lap entries; must be a power of 2 and at least 2.
- IDXW, 2, log2(DEPTH); width of lap indices.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- trig  in  1  start/stop pulse, one cycle, already debounced.
- split  in  1  lap/clear pulse, one cycle.
- review  in  1  step-through-laps pulse, one cycle.
- cnt_value  in  WIDTH  current counter value from the datapath.
- init_regs  out  1  clear request to the counter regs.
- count_enabled  out  1  counter increment enable.
- disp_value  out  WIDTH  value to display (registered).
- lap_count  out  IDXW+1  number of stored laps, 0..DEPTH.
- lap_idx  out  IDXW  index shown while in REVIEW; 0 otherwise.
- lap_full  out  1  high when lap_count == DEPTH.
- lap_ovf  out  1  sticky flag: a split was dropped because the buffer was full.

Behaviour:
- One clock domain (clk). reset is synchronous and active-high and has priority over everything.
- Reset values:
  - state = IDLE; init_regs = 1; count_enabled = 0.
  - disp_value = 0; lap_count = 0; lap_idx = 0; lap_full = 0; lap_ovf = 0.
  - Lap memory contents are don't-care.
- States: IDLE, RUN, PAUSED, REVIEW.
- Outputs by state (Moore, decoded from registered state):
  - init_regs = 1 only in IDLE.
  - count_enabled = 1 only in RUN.
- Input priority when several pulses arrive in the same cycle: trig > split > review. Only the highest-priority pulse acts; the others are ignored.
- IDLE:
  - trig -> RUN.
  - split and review: no effect.
- RUN:
  - trig -> PAUSED.
  - split: write cnt_value as sampled that cycle into mem[lap_count], and increment lap_count. State stays RUN.
  - split when lap_full: no write, lap_count unchanged, lap_ovf <= 1.
  - review: ignored.
- PAUSED:
  - trig -> RUN.
  - split -> IDLE. Clears lap_count, lap_ovf and lap_idx in the same edge.
  - review with lap_count > 0 -> REVIEW, lap_idx <= 0.
  - review with lap_count == 0: ignored.
- REVIEW:
  - review: lap_idx <= (lap_idx == lap_count-1) ? 0 : lap_idx+1 (wraps at the number stored, not at DEPTH).
  - trig -> PAUSED, lap_idx <= 0.
  - split -> IDLE, with the same clears as from PAUSED.
- disp_value is registered with one-cycle latency:
  - REVIEW: disp_value <= mem[next lap_idx]. The stored lap appears on the same edge that enters REVIEW or advances the index.
  - Otherwise: disp_value <= cnt_value.
- Split capture latency: the entry is visible in mem, and lap_count is updated, on the edge after the split pulse.
- lap_full is combinational from lap_count.
- lap_ovf clears only on reset or on a transition into IDLE.
- Reset mid-operation (any state, even coincident with button pulses) -> IDLE next edge with all reset values; the pulses are discarded.
- The counter value itself is not modified here. The datapath clears on init_regs and holds when count_enabled = 0.

Decomposition:
- Shared package/header (stopwatch_pkg):
  - state encoding constants: IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, REVIEW = 2'd3.
  - default WIDTH and DEPTH.
- One natural sub-module: lap_mem. DEPTH x WIDTH register file with synchronous write (we, waddr, wdata) and asynchronous read (raddr, rdata). Not reset.
- The FSM, lap_count/lap_idx counters and display mux stay in lap_ctl.

Test Plan:
1. Reset for 2 cycles, then release -> init_regs = 1, count_enabled = 0, disp_value = 0, lap_count = 0. trig -> next edge count_enabled = 1, init_regs = 0.
2. In RUN, split with cnt_value = 16'h0123, later split with 16'h0456 -> lap_count = 2. trig -> PAUSED. review -> disp_value = 16'h0123, lap_idx = 0. review -> disp_value = 16'h0456, lap_idx = 1. review -> wraps to 16'h0123, lap_idx = 0.
3. In RUN, 5 splits with DEPTH = 4 -> lap_count = 4, lap_full = 1, lap_ovf = 1, mem[3] holds the 4th value. PAUSED then split -> IDLE with lap_count = 0, lap_ovf = 0, init_regs = 1.
4. Simultaneous trig+split in RUN -> PAUSED, no lap stored (lap_count unchanged). Simultaneous split+review in PAUSED with laps stored -> IDLE.
5. review in PAUSED with lap_count = 0 -> stays PAUSED, disp_value follows cnt_value. review in IDLE or RUN -> ignored.
6. reset asserted in REVIEW together with a trig pulse -> next edge IDLE, all outputs at reset values. Subsequent trig starts a fresh RUN with lap_count = 0.
